// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse packet consumer: clamped cursor position, button state and a
// left-drag selection FSM emitting zoom rectangles, clicks and zoom-out pulses.
module mouse_pos_tracker #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int SPEED_SHIFT = 0,
    parameter int MIN_SEL     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_byte_valid,
    input  logic [7:0]     ps2_byte_1,
    input  logic [7:0]     ps2_byte_2,
    input  logic [7:0]     ps2_byte_3,
    output logic [X_W-1:0] mouse_x,
    output logic [Y_W-1:0] mouse_y,
    output logic [2:0]     mouse_btn,
    output logic           pos_valid,
    output logic           sel_valid,
    output logic [X_W-1:0] sel_x0,
    output logic [X_W-1:0] sel_x1,
    output logic [Y_W-1:0] sel_y0,
    output logic [Y_W-1:0] sel_y1,
    output logic           click_valid,
    output logic           zoom_out,
    output logic [7:0]     sync_err_cnt
);

    localparam int NWX = X_W + SPEED_SHIFT + 2;
    localparam int NWY = Y_W + SPEED_SHIFT + 2;
    localparam logic signed [NWX-1:0] X_MAX = NWX'(H_RES - 1);
    localparam logic signed [NWY-1:0] Y_MAX = NWY'(V_RES - 1);

    typedef enum logic {IDLE, DRAG} state_t;

    // stage 1: registered packet
    logic              p_vld_q, p_vld_d;
    logic signed [8:0] p_dx_q, p_dx_d;
    logic signed [8:0] p_dy_q, p_dy_d;
    logic [2:0]        p_btn_q, p_btn_d;
    logic [7:0]        err_q, err_d;

    // stage 2: cursor
    logic [X_W-1:0]    mx_q, mx_d;
    logic [Y_W-1:0]    my_q, my_d;
    logic [2:0]        btn_q, btn_d;
    logic [2:0]        prev_btn_q, prev_btn_d;
    logic              pos_vld_q, pos_vld_d;
    logic signed [NWX-1:0] dx_s, nx;
    logic signed [NWY-1:0] dy_s, ny;

    // stage 3: selection FSM
    state_t            state_q, state_d;
    logic [X_W-1:0]    ax_q, ax_d;
    logic [Y_W-1:0]    ay_q, ay_d;
    logic [X_W-1:0]    sx0_q, sx0_d, sx1_q, sx1_d;
    logic [Y_W-1:0]    sy0_q, sy0_d, sy1_q, sy1_d;
    logic              selv_q, selv_d;
    logic              clkv_q, clkv_d;
    logic              zoom_q, zoom_d;
    logic              l_rise, l_fall, r_rise;
    logic [X_W-1:0]    rx0, rx1;
    logic [Y_W-1:0]    ry0, ry1;
    logic              big;

    always_comb begin
        p_vld_d = ps2_byte_valid && ps2_byte_1[3];
        p_dx_d  = p_dx_q;
        p_dy_d  = p_dy_q;
        p_btn_d = p_btn_q;
        err_d   = err_q;
        if (p_vld_d) begin
            p_dx_d  = ps2_byte_1[6] ? 9'sd0 : {ps2_byte_1[4], ps2_byte_2};
            p_dy_d  = ps2_byte_1[7] ? 9'sd0 : {ps2_byte_1[5], ps2_byte_3};
            p_btn_d = ps2_byte_1[2:0];
        end
        if (ps2_byte_valid && !ps2_byte_1[3] && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    // positive y delta means up, i.e. towards row 0
    always_comb begin
        dx_s       = NWX'(p_dx_q) <<< SPEED_SHIFT;
        dy_s       = NWY'(p_dy_q) <<< SPEED_SHIFT;
        nx         = signed'(NWX'(mx_q)) + dx_s;
        ny         = signed'(NWY'(my_q)) - dy_s;
        mx_d       = mx_q;
        my_d       = my_q;
        btn_d      = btn_q;
        prev_btn_d = prev_btn_q;
        pos_vld_d  = p_vld_q;
        if (p_vld_q) begin
            if (nx < 0)          mx_d = '0;
            else if (nx > X_MAX) mx_d = X_W'(H_RES - 1);
            else                 mx_d = nx[X_W-1:0];
            if (ny < 0)          my_d = '0;
            else if (ny > Y_MAX) my_d = Y_W'(V_RES - 1);
            else                 my_d = ny[Y_W-1:0];
            btn_d      = p_btn_q;
            prev_btn_d = btn_q;
        end
    end

    always_comb begin
        l_rise = pos_vld_q && btn_q[0] && !prev_btn_q[0];
        l_fall = pos_vld_q && !btn_q[0] && prev_btn_q[0];
        r_rise = pos_vld_q && btn_q[1] && !prev_btn_q[1];
        rx0    = (ax_q < mx_q) ? ax_q : mx_q;
        rx1    = (ax_q < mx_q) ? mx_q : ax_q;
        ry0    = (ay_q < my_q) ? ay_q : my_q;
        ry1    = (ay_q < my_q) ? my_q : ay_q;
        big    = ((rx1 - rx0) >= X_W'(MIN_SEL)) &&
                 ((ry1 - ry0) >= Y_W'(MIN_SEL));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (l_rise) state_d = DRAG;
            DRAG: if (l_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ax_d   = ax_q;
        ay_d   = ay_q;
        sx0_d  = sx0_q;
        sx1_d  = sx1_q;
        sy0_d  = sy0_q;
        sy1_d  = sy1_q;
        selv_d = 1'b0;
        clkv_d = 1'b0;
        zoom_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (l_rise) begin
                    ax_d = mx_q;
                    ay_d = my_q;
                end else if (r_rise) begin
                    zoom_d = 1'b1;
                end
            end
            DRAG: begin
                if (l_fall && big) begin
                    selv_d = 1'b1;
                    sx0_d  = rx0;
                    sx1_d  = rx1;
                    sy0_d  = ry0;
                    sy1_d  = ry1;
                end else if (l_fall) begin
                    clkv_d = 1'b1;
                    sx0_d  = mx_q;
                    sx1_d  = mx_q;
                    sy0_d  = my_q;
                    sy1_d  = my_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld_q    <= 1'b0;
            p_dx_q     <= '0;
            p_dy_q     <= '0;
            p_btn_q    <= '0;
            err_q      <= '0;
            mx_q       <= X_W'(X_INIT);
            my_q       <= Y_W'(Y_INIT);
            btn_q      <= '0;
            prev_btn_q <= '0;
            pos_vld_q  <= 1'b0;
            ax_q       <= '0;
            ay_q       <= '0;
            sx0_q      <= '0;
            sx1_q      <= '0;
            sy0_q      <= '0;
            sy1_q      <= '0;
            selv_q     <= 1'b0;
            clkv_q     <= 1'b0;
            zoom_q     <= 1'b0;
        end else begin
            p_vld_q    <= p_vld_d;
            p_dx_q     <= p_dx_d;
            p_dy_q     <= p_dy_d;
            p_btn_q    <= p_btn_d;
            err_q      <= err_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            btn_q      <= btn_d;
            prev_btn_q <= prev_btn_d;
            pos_vld_q  <= pos_vld_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            sx0_q      <= sx0_d;
            sx1_q      <= sx1_d;
            sy0_q      <= sy0_d;
            sy1_q      <= sy1_d;
            selv_q     <= selv_d;
            clkv_q     <= clkv_d;
            zoom_q     <= zoom_d;
        end
    end

    assign mouse_x      = mx_q;
    assign mouse_y      = my_q;
    assign mouse_btn    = btn_q;
    assign pos_valid    = pos_vld_q;
    assign sel_valid    = selv_q;
    assign sel_x0       = sx0_q;
    assign sel_x1       = sx1_q;
    assign sel_y0       = sy0_q;
    assign sel_y1       = sy1_q;
    assign click_valid  = clkv_q;
    assign zoom_out     = zoom_q;
    assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed-vector bench for mouse_pos_tracker: cursor motion, clamping,
// drag rectangles, clicks, zoom-out and sync-error handling.
module tb_mouse_pos_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [7:0] b1, b2, b3;
    logic [9:0] mouse_x, mouse_y;
    logic [2:0] mouse_btn;
    logic       pos_valid, sel_valid, click_valid, zoom_out;
    logic [9:0] sel_x0, sel_x1, sel_y0, sel_y1;
    logic [7:0] sync_err_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int pos_cnt = 0, sel_cnt = 0, clk_cnt = 0, zoom_cnt = 0;
    int p0, s0, c0, z0;

    always #5 clk = ~clk;

    mouse_pos_tracker dut (
        .clk(clk), .rst(rst),
        .ps2_byte_valid(vld),
        .ps2_byte_1(b1), .ps2_byte_2(b2), .ps2_byte_3(b3),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
        .pos_valid(pos_valid), .sel_valid(sel_valid),
        .sel_x0(sel_x0), .sel_x1(sel_x1),
        .sel_y0(sel_y0), .sel_y1(sel_y1),
        .click_valid(click_valid), .zoom_out(zoom_out),
        .sync_err_cnt(sync_err_cnt)
    );

    always @(negedge clk) begin
        if (pos_valid)   pos_cnt++;
        if (sel_valid)   sel_cnt++;
        if (click_valid) clk_cnt++;
        if (zoom_out)    zoom_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
        @(negedge clk);
        vld = 1'b1; b1 = a; b2 = b; b3 = c;
        @(negedge clk);
        vld = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic snap;
        p0 = pos_cnt; s0 = sel_cnt; c0 = clk_cnt; z0 = zoom_cnt;
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; b1 = '0; b2 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_x", mouse_x, 320);
        chk("rst_y", mouse_y, 240);
        chk("rst_btn", mouse_btn, 0);
        chk("rst_err", sync_err_cnt, 0);
        chk("rst_pv", pos_valid, 0);
        chk("rst_sx0", sel_x0, 0);

        // single packet with exact latency
        vld = 1'b1; b1 = 8'h08; b2 = 8'h05; b3 = 8'h03;
        @(negedge clk);
        vld = 1'b0;
        chk("t1_pv_n1", pos_valid, 0);
        @(negedge clk);
        chk("t1_pv_n2", pos_valid, 1);
        chk("t1_x", mouse_x, 325);
        chk("t1_y", mouse_y, 237);
        repeat (3) @(negedge clk);

        // clamp low then high
        repeat (4) pkt(8'h18, 8'h80, 8'h00);
        chk("t2_xmin", mouse_x, 0);
        snap();
        repeat (6) pkt(8'h08, 8'h7F, 8'h00);
        chk("t2_xmax", mouse_x, 639);
        chk("t2_y", mouse_y, 237);
        chk("t2_pvcnt", pos_cnt - p0, 6);

        // back-to-back packets
        snap();
        @(negedge clk);
        vld = 1'b1; b1 = 8'h18; b2 = 8'hFF; b3 = 8'h00;
        @(negedge clk);
        b2 = 8'hFE;
        @(negedge clk);
        vld = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_pv", pos_cnt - p0, 2);
        chk("b2b_x", mouse_x, 636);

        // go to (100,100)
        do_reset();
        pkt(8'h18, 8'h80, 8'h00);
        pkt(8'h18, 8'hA4, 8'h00);
        pkt(8'h08, 8'h00, 8'h7F);
        pkt(8'h08, 8'h00, 8'h0D);
        chk("t3_x", mouse_x, 100);
        chk("t3_y", mouse_y, 100);

        // drag to a rectangle
        snap();
        pkt(8'h09, 8'h00, 8'h00);
        chk("t3_btn", mouse_btn, 1);
        pkt(8'h09, 8'h32, 8'h14);
        pkt(8'h08, 8'h00, 8'h00);
        chk("t3_sel", sel_cnt - s0, 1);
        chk("t3_clk", clk_cnt - c0, 0);
        chk("t3_x0", sel_x0, 100);
        chk("t3_x1", sel_x1, 150);
        chk("t3_y0", sel_y0, 80);
        chk("t3_y1", sel_y1, 100);

        // short drag is a click
        snap();
        pkt(8'h09, 8'h00, 8'h00);
        pkt(8'h09, 8'h02, 8'h00);
        pkt(8'h08, 8'h00, 8'h00);
        chk("t4_clk", clk_cnt - c0, 1);
        chk("t4_sel", sel_cnt - s0, 0);
        chk("t4_x0", sel_x0, 152);
        chk("t4_y0", sel_y0, 80);

        // right press from idle
        snap();
        pkt(8'h0A, 8'h00, 8'h00);
        pkt(8'h08, 8'h00, 8'h00);
        chk("t4_zoom", zoom_cnt - z0, 1);

        // left and right rising together: left wins
        snap();
        pkt(8'h0B, 8'h00, 8'h00);
        pkt(8'h08, 8'h00, 8'h00);
        chk("t4_lr_zoom", zoom_cnt - z0, 0);
        chk("t4_lr_clk", clk_cnt - c0, 1);

        // sync error and overflow
        snap();
        pkt(8'h00, 8'h05, 8'h05);
        chk("t5_err", sync_err_cnt, 1);
        chk("t5_pv", pos_cnt - p0, 0);
        chk("t5_xkeep", mouse_x, 152);
        pkt(8'h48, 8'h10, 8'h10);
        chk("t5_ovx", mouse_x, 152);
        chk("t5_ovy", mouse_y, 64);

        // reset mid-drag
        pkt(8'h09, 8'h00, 8'h00);
        do_reset();
        chk("t6_x", mouse_x, 320);
        chk("t6_y", mouse_y, 240);
        chk("t6_btn", mouse_btn, 0);
        chk("t6_err", sync_err_cnt, 0);
        chk("t6_sx0", sel_x0, 0);
        snap();
        pkt(8'h08, 8'h00, 8'h00);
        chk("t6_sel", sel_cnt - s0, 0);
        chk("t6_clk", clk_cnt - c0, 0);

        // exactly MIN_SEL in both axes is a rectangle
        pkt(8'h09, 8'h00, 8'h00);
        pkt(8'h09, 8'h04, 8'h04);
        pkt(8'h08, 8'h00, 8'h00);
        chk("min_sel", sel_cnt - s0, 1);
        chk("min_x0", sel_x0, 320);
        chk("min_x1", sel_x1, 324);
        chk("min_y0", sel_y0, 236);
        chk("min_y1", sel_y1, 240);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
